// File: rtl/uart_cmd_parser_pkg.sv
// Shared opcodes, state encoding and frame-validation helper for the UART
// command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] OPC_WR   = 8'hA5;
  localparam logic [7:0] OPC_RD   = 8'hA1;
  localparam logic [7:0] RD_DUMMY = 8'hFF;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_OP   = 2'd2,
    S_PEND = 2'd3
  } state_e;

  // A read frame carries a dummy data byte that must be RD_DUMMY.
  function automatic logic opcode_ok(input logic [7:0] opc, input logic [7:0] data);
    return (opc == OPC_WR) || ((opc == OPC_RD) && (data == RD_DUMMY));
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module uart_idle_timer
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 20
) (
  input  logic clk50M,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles address/data/opcode UART frames into single-cycle SPI EEPROM
// read/write commands, holding a command while the SPI engine is busy.
//
// state  | meaning
// S_ADDR | idle, waiting for the address byte
// S_DATA | address captured, waiting for the data byte (timeout armed)
// S_OP   | data captured, waiting for the opcode byte (timeout armed)
// S_PEND | valid command held until spi_busy drops; new bytes are dropped
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 20
) (
  input  logic       clk50M,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       spi_busy,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_data,
  output logic       spi_wr,
  output logic       spi_rd,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overrun_err,
  output logic [7:0] cmd_cnt
);

  state_e     state_q, state_d;
  logic [7:0] addr_sh_q, addr_sh_d;
  logic [7:0] data_sh_q, data_sh_d;
  logic       pend_rd_q, pend_rd_d;
  logic [7:0] spi_addr_q, spi_addr_d;
  logic [7:0] spi_data_q, spi_data_d;
  logic [7:0] cmd_cnt_q, cmd_cnt_d;
  logic       spi_wr_q, spi_wr_d;
  logic       spi_rd_q, spi_rd_d;
  logic       frame_err_q, frame_err_d;
  logic       timeout_err_q, timeout_err_d;
  logic       overrun_err_q, overrun_err_d;

  logic       opc_valid;
  logic       issue, issue_rd;
  logic       tmr_clear, tmr_en, tmr_expired;

  assign opc_valid = opcode_ok(rx_data, data_sh_q);

  // Clearing on the next state keeps the counter at zero outside S_DATA/S_OP
  // and guarantees it starts from zero on entry.
  assign tmr_en    = (state_q == S_DATA) || (state_q == S_OP);
  assign tmr_clear = rx_done || !((state_d == S_DATA) || (state_d == S_OP));

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_idle_timer (
    .clk50M (clk50M),
    .rst_i  (rst_i),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk50M) begin
    if (rst_i) begin
      state_q       <= S_ADDR;
      addr_sh_q     <= '0;
      data_sh_q     <= '0;
      pend_rd_q     <= 1'b0;
      spi_addr_q    <= '0;
      spi_data_q    <= '0;
      cmd_cnt_q     <= '0;
      spi_wr_q      <= 1'b0;
      spi_rd_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_sh_q     <= addr_sh_d;
      data_sh_q     <= data_sh_d;
      pend_rd_q     <= pend_rd_d;
      spi_addr_q    <= spi_addr_d;
      spi_data_q    <= spi_data_d;
      cmd_cnt_q     <= cmd_cnt_d;
      spi_wr_q      <= spi_wr_d;
      spi_rd_q      <= spi_rd_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ADDR: if (rx_done) state_d = S_DATA;
      S_DATA: begin
        if (rx_done)          state_d = S_OP;
        else if (tmr_expired) state_d = S_ADDR;
      end
      S_OP: begin
        if (rx_done)          state_d = (opc_valid && spi_busy) ? S_PEND : S_ADDR;
        else if (tmr_expired) state_d = S_ADDR;
      end
      S_PEND: if (!spi_busy) state_d = S_ADDR;
      default: state_d = S_ADDR;
    endcase
  end

  always_comb begin
    addr_sh_d     = addr_sh_q;
    data_sh_d     = data_sh_q;
    pend_rd_d     = pend_rd_q;
    spi_addr_d    = spi_addr_q;
    spi_data_d    = spi_data_q;
    cmd_cnt_d     = cmd_cnt_q;
    spi_wr_d      = 1'b0;
    spi_rd_d      = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;
    issue         = 1'b0;
    issue_rd      = 1'b0;

    unique case (state_q)
      S_ADDR: if (rx_done) addr_sh_d = rx_data;
      S_DATA: begin
        if (rx_done)          data_sh_d = rx_data;
        else if (tmr_expired) timeout_err_d = 1'b1;
      end
      S_OP: begin
        if (rx_done) begin
          if (!opc_valid) begin
            frame_err_d = 1'b1;
          end else if (spi_busy) begin
            pend_rd_d = (rx_data == OPC_RD);
          end else begin
            issue    = 1'b1;
            issue_rd = (rx_data == OPC_RD);
          end
        end else if (tmr_expired) begin
          timeout_err_d = 1'b1;
        end
      end
      S_PEND: begin
        overrun_err_d = rx_done;
        if (!spi_busy) begin
          issue    = 1'b1;
          issue_rd = pend_rd_q;
        end
      end
      default: ;
    endcase

    if (issue) begin
      spi_addr_d = addr_sh_q;
      spi_data_d = data_sh_q;
      spi_wr_d   = !issue_rd;
      spi_rd_d   = issue_rd;
      cmd_cnt_d  = cmd_cnt_q + 8'd1;
    end
  end

  assign spi_addr    = spi_addr_q;
  assign spi_data    = spi_data_q;
  assign spi_wr      = spi_wr_q;
  assign spi_rd      = spi_rd_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign cmd_cnt     = cmd_cnt_q;

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning the inter-byte timeout in clk50M cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 20, meaning the timeout counter width; it SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clk50M  input  1  system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received UART byte, valid only when rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe: rx_data holds a new byte.
REQ-007 spi_busy  input  1  SPI EEPROM engine busy; no command may be issued while it is 1.
REQ-008 spi_addr  output  8  EEPROM address of the issued command.
REQ-009 spi_data  output  8  write data of the issued command.
REQ-010 spi_wr  output  1  one-cycle write-command pulse.
REQ-011 spi_rd  output  1  one-cycle read-command pulse.
REQ-012 frame_err  output  1  one-cycle pulse: bad opcode, or read with data byte other than 0xFF.
REQ-013 timeout_err  output  1  one-cycle pulse: partial frame abandoned.
REQ-014 overrun_err  output  1  one-cycle pulse: byte dropped while a command is pending.
REQ-015 cmd_cnt  output  8  count of issued commands; wraps 0xFF->0x00.

Function
REQ-016 A frame SHALL be three bytes in order: address, data, opcode; opcode 0xA5 = write, 0xA1 = read (data byte must be 0xFF).
REQ-017 FSM states SHALL be S_ADDR, S_DATA, S_OP, S_PEND.
REQ-018 S_ADDR: rx_done -> latch rx_data into an address shadow, go to S_DATA.
REQ-019 S_DATA: rx_done -> latch rx_data into a data shadow, go to S_OP.
REQ-020 S_OP with rx_done, valid opcode, spi_busy=0: on the next edge, copy both shadows to spi_addr/spi_data, pulse spi_wr or spi_rd for one cycle, increment cmd_cnt, return to S_ADDR (latency 1 cycle from the opcode rx_done).
REQ-021 S_OP with rx_done, valid opcode, spi_busy=1: record the opcode type and go to S_PEND.
REQ-022 S_PEND: the first cycle with spi_busy=0 SHALL issue the command as in REQ-020, with a 1-cycle latency, and return to S_ADDR.
REQ-023 S_OP with rx_done and an invalid opcode, or 0xA1 with data shadow other than 0xFF: pulse frame_err, issue nothing, return to S_ADDR.
REQ-024 In S_DATA/S_OP the timeout counter SHALL clear on every rx_done and on entry, and increment otherwise.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 without rx_done: pulse timeout_err and go to S_ADDR.
REQ-026 The counter SHALL be held at 0 in S_ADDR and S_PEND; no timeout applies there.
REQ-027 rx_done in the same cycle as timeout expiry: the byte SHALL be accepted and no timeout_err raised.
REQ-028 rx_done in S_PEND: the byte SHALL be dropped and overrun_err pulsed; if spi_busy=0 in that same cycle, the pending command SHALL still issue.
REQ-029 spi_wr and spi_rd SHALL never be asserted together; at most one error pulse per cycle.
REQ-030 spi_addr and spi_data SHALL change only when a command issues and stay stable until the next issue.

Reset
REQ-031 rst_i=1 at any clock edge SHALL force: state S_ADDR; spi_addr, spi_data, shadows, counter and cmd_cnt = 0; all pulse outputs = 0.
REQ-032 Reset mid-frame or in S_PEND SHALL discard the partial or pending command, with no pulse issued.

Structure
REQ-033 A shared package/header SHALL hold OPC_WR=8'hA5, OPC_RD=8'hA1, RD_DUMMY=8'hFF and the state encodings.
REQ-034 The timeout counter SHALL be a sub-module, uart_idle_timer (inputs clear and enable; output expired).
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Bytes 0x12, 0x34, 0xA5 with spi_busy=0 -> spi_wr one cycle after the 3rd rx_done, spi_addr=0x12, spi_data=0x34, cmd_cnt=1.
REQ-037 Bytes 0x40, 0xFF, 0xA1 -> spi_rd pulse, spi_addr=0x40; bytes 0x40, 0x00, 0xA1 -> frame_err, no spi_rd.
REQ-038 Bytes 0x05, 0x06, then silence of TIMEOUT_CYCLES cycles -> timeout_err; then 0x07, 0x08, 0xA5 -> spi_wr with addr 0x07, data 0x08.
REQ-039 spi_busy=1, then 0x10, 0x20, 0xA5, then byte 0x99 -> overrun_err; spi_busy falls -> spi_wr next cycle with addr 0x10, data 0x20.
REQ-040 rst_i asserted after byte 0x11 -> no pulse; next frame 0x22, 0x33, 0xA5 -> addr 0x22; 256 issued commands -> cmd_cnt wraps to 0x00.
